// File: rtl/serial_compare.sv
// serial_compare: MSB-first chunked magnitude comparator, valid/ready in and out.
// Build option: define SERIAL_COMPARE_EARLY_EXIT_EN to finish at the first differing chunk.
module serial_compare #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             SIGNED,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             O_lt,
    output logic             O_eq,
    output logic             O_gt,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t r_state, w_next;

    logic [WIDTH-1:0] r_a, r_b;
    logic             r_signed, r_first, r_issue;
    logic [CW-1:0]    r_cnt;
    logic             r_c_vld, r_c_lt, r_c_gt, r_c_last;
    logic             r_lt, r_eq, r_gt;
`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
    logic             r_hit, r_hlt;
`endif

    logic             w_accept, w_finish, w_fin_lt, w_fin_gt, w_fin_eq;
    logic [CHUNK-1:0] w_sfix, w_chunk_a, w_chunk_b;

    // Flipping the sign bit of the top chunk maps two's complement onto unsigned order.
    always_comb begin
        w_sfix          = '0;
        w_sfix[CHUNK-1] = r_first & r_signed;
        w_chunk_a       = r_a[WIDTH-1 -: CHUNK] ^ w_sfix;
        w_chunk_b       = r_b[WIDTH-1 -: CHUNK] ^ w_sfix;
    end

    // The chunk compare is registered first and acted on the following cycle,
    // so the comparator never sits in front of the state/flag logic.
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
    assign w_finish = r_c_vld & (r_c_lt | r_c_gt | r_c_last);
    assign w_fin_lt = r_c_lt;
    assign w_fin_gt = r_c_gt;
    assign w_fin_eq = ~r_c_lt & ~r_c_gt;
`else
    assign w_finish = r_c_vld & r_c_last;
    assign w_fin_lt = r_hit ? r_hlt  : r_c_lt;
    assign w_fin_gt = r_hit ? ~r_hlt : r_c_gt;
    assign w_fin_eq = ~r_hit & ~r_c_lt & ~r_c_gt;
`endif

    assign w_accept  = in_valid & in_ready;
    assign O_lt      = r_lt;
    assign O_eq      = r_eq;
    assign O_gt      = r_gt;

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = ~RESET;
                if (in_valid && !RESET) w_next = SCAN;
            end
            SCAN: if (w_finish) w_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_first  <= 1'b0;
            r_issue  <= 1'b0;
            r_cnt    <= '0;
            r_c_vld  <= 1'b0;
            r_c_lt   <= 1'b0;
            r_c_gt   <= 1'b0;
            r_c_last <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
            r_hit    <= 1'b0;
            r_hlt    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_a      <= I0;
                    r_b      <= I1;
                    r_signed <= SIGNED;
                    r_cnt    <= CW'(N - 1);
                    r_first  <= 1'b1;
                    r_issue  <= 1'b1;
                    r_c_vld  <= 1'b0;
`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
                    r_hit    <= 1'b0;
`endif
                end
                SCAN: begin
                    if (r_issue) begin
                        r_c_lt   <= w_chunk_a < w_chunk_b;
                        r_c_gt   <= w_chunk_a > w_chunk_b;
                        r_c_last <= (r_cnt == '0);
                        r_c_vld  <= 1'b1;
                        r_first  <= 1'b0;
                        r_issue  <= (r_cnt != '0);
                        if (r_cnt != '0) begin
                            r_a   <= r_a << CHUNK;
                            r_b   <= r_b << CHUNK;
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
                    // Keep only the most significant difference.
                    if (r_c_vld && (r_c_lt || r_c_gt) && !r_hit) begin
                        r_hit <= 1'b1;
                        r_hlt <= r_c_lt;
                    end
`endif
                    if (w_finish) begin
                        r_lt <= w_fin_lt;
                        r_eq <= w_fin_eq;
                        r_gt <= w_fin_gt;
                    end
                end
                DONE: if (out_ready) begin
                    r_lt    <= 1'b0;
                    r_eq    <= 1'b0;
                    r_gt    <= 1'b0;
                    r_c_vld <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
